button_conditioner: RTL and testbench

Upstream stage of the game FSM. Takes the four raw, asynchronous player buttons and synchronises and debounces each one. Converts debounced activity into clean single-cycle press/release events with a 2-bit button index, and flags multi-button chords. The FSM consumes press_valid/press_idx instead of raw BTN levels.

---
 rtl/simon_pkg.sv | 16 +
 rtl/btn_debounce_ch.sv | 50 +++++
 rtl/button_conditioner.sv | 130 +++++++++++++
 tb/tb_button_conditioner.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/simon_pkg.sv
// Shared types and defaults for the Simon game front end.
package simon_pkg;

  localparam int unsigned NUM_BTN_DEF         = 4;
  localparam int unsigned TICKS_PER_MILLI_DEF = 50;
  localparam int unsigned IDX_W               = 2;

  typedef logic [IDX_W-1:0] btn_idx_t;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    HELD     = 2'd1,
    WAIT_REL = 2'd2
  } cond_state_t;

endpackage

// File: rtl/btn_debounce_ch.sv
// One button channel: input synchroniser, ms-tick debounce counter and stable level.
module btn_debounce_ch #(
  parameter int unsigned DEBOUNCE_MS = 10,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw_i,
  input  logic ms_tick_i,
  output logic level_o
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_MS + 1);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   level_q, level_d;

  // A level is accepted only after DEBOUNCE_MS consecutive disagreeing ticks.
  always_comb begin
    sync_d  = {sync_q[SYNC_STAGES-2:0], btn_raw_i};
    cnt_d   = cnt_q;
    level_d = level_q;
    if (sync_q[SYNC_STAGES-1] == level_q) begin
      cnt_d = '0;
    end else if (ms_tick_i) begin
      if (cnt_q == CNT_W'(DEBOUNCE_MS - 1)) begin
        level_d = ~level_q;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      sync_q  <= '0;
      cnt_q   <= '0;
      level_q <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
    end
  end

  assign level_o = level_q;

endmodule

// File: rtl/button_conditioner.sv
// Debounces the player buttons and turns stable levels into press/release/chord events.
module button_conditioner #(
  parameter int unsigned NUM_BTN         = simon_pkg::NUM_BTN_DEF,
  parameter int unsigned TICKS_PER_MILLI = simon_pkg::TICKS_PER_MILLI_DEF,
  parameter int unsigned DEBOUNCE_MS     = 10,
  parameter int unsigned SYNC_STAGES     = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_BTN-1:0]  btn_raw,
  input  logic                enable,
  output logic [NUM_BTN-1:0]  btn_level,
  output logic                press_valid,
  output logic [1:0]          press_idx,
  output logic                release_valid,
  output logic                chord_err,
  output logic                any_held
);
  import simon_pkg::*;

  localparam int unsigned PRE_W = (TICKS_PER_MILLI > 1) ? $clog2(TICKS_PER_MILLI) : 1;

  if (NUM_BTN > 4 || NUM_BTN < 1) begin : g_bad_num_btn
    $error("NUM_BTN must be 1..4");
  end
  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("SYNC_STAGES must be at least 2");
  end

  logic [PRE_W-1:0]   pre_q, pre_d;
  logic               ms_tick;
  logic [NUM_BTN-1:0] lvl, prev_q, rise, fall, idx_mask, other_rise;
  logic               single_rise;
  btn_idx_t           rise_idx;

  cond_state_t state_q, state_d;
  logic        press_q, press_d, rel_q, rel_d, chord_q, chord_d;
  btn_idx_t    idx_q, idx_d;

  assign ms_tick = (pre_q == PRE_W'(TICKS_PER_MILLI - 1));
  assign pre_d   = ms_tick ? '0 : pre_q + PRE_W'(1);

  for (genvar g = 0; g < NUM_BTN; g++) begin : g_ch
    btn_debounce_ch #(
      .DEBOUNCE_MS (DEBOUNCE_MS),
      .SYNC_STAGES (SYNC_STAGES)
    ) u_ch (
      .clk       (clk),
      .rst       (rst),
      .btn_raw_i (btn_raw[g]),
      .ms_tick_i (ms_tick),
      .level_o   (lvl[g])
    );
  end

  assign rise        = lvl & ~prev_q;
  assign fall        = ~lvl & prev_q;
  assign idx_mask    = NUM_BTN'(1) << idx_q;
  assign other_rise  = rise & ~idx_mask;
  assign single_rise = (rise != '0) && ((rise & (rise - NUM_BTN'(1))) == '0);

  always_comb begin
    rise_idx = '0;
    for (int i = 0; i < int'(NUM_BTN); i++) begin
      if (rise[i]) rise_idx = btn_idx_t'(i);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= WAIT_REL;
      pre_q   <= '0;
      prev_q  <= '0;
      press_q <= 1'b0;
      rel_q   <= 1'b0;
      chord_q <= 1'b0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      pre_q   <= pre_d;
      prev_q  <= lvl;
      press_q <= press_d;
      rel_q   <= rel_d;
      chord_q <= chord_d;
      idx_q   <= idx_d;
    end
  end

  // A foreign rise while held beats a same-cycle release.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (rise != '0) state_d = (enable && single_rise) ? HELD : WAIT_REL;
      end
      HELD: begin
        if (other_rise != '0)            state_d = WAIT_REL;
        else if ((fall & idx_mask) != '0) state_d = IDLE;
      end
      WAIT_REL: begin
        if (lvl == '0) state_d = IDLE;
      end
      default: state_d = WAIT_REL;
    endcase
  end

  always_comb begin
    press_d = 1'b0;
    rel_d   = 1'b0;
    chord_d = 1'b0;
    idx_d   = idx_q;
    if (state_q == IDLE && enable && rise != '0) begin
      press_d = single_rise;
      chord_d = !single_rise;
      if (single_rise) idx_d = rise_idx;
    end
    if (state_q == HELD) begin
      chord_d = (other_rise != '0);
      rel_d   = (other_rise == '0) && ((fall & idx_mask) != '0);
    end
  end

  assign btn_level     = lvl;
  assign press_valid   = press_q;
  assign press_idx     = idx_q;
  assign release_valid = rel_q;
  assign chord_err     = chord_q;
  assign any_held      = |lvl;

endmodule

// File: tb/tb_button_conditioner.sv
// Randomised bench for button_conditioner with a rule-level model and event scoreboard.
module tb_button_conditioner;

  localparam int T = 4;
  localparam int D = 3;
  localparam int S = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] btn_raw;
  logic       enable;
  logic [3:0] btn_level;
  logic       press_valid;
  logic [1:0] press_idx;
  logic       release_valid;
  logic       chord_err;
  logic       any_held;

  button_conditioner #(
    .NUM_BTN         (4),
    .TICKS_PER_MILLI (T),
    .DEBOUNCE_MS     (D),
    .SYNC_STAGES     (S)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .btn_raw       (btn_raw),
    .enable        (enable),
    .btn_level     (btn_level),
    .press_valid   (press_valid),
    .press_idx     (press_idx),
    .release_valid (release_valid),
    .chord_err     (chord_err),
    .any_held      (any_held)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
  endtask

  // ---------------- reference model (evaluated on each rising edge) ----------------
  // Event codes: 1 press, 2 release, 3 chord.
  int         exp_q[$];
  int         m_edge  = 0;
  logic [3:0] m_lvl   = '0;
  logic [3:0] m_prev  = '0;
  int         m_since[4] = '{-1, -1, -1, -1};
  logic [3:0] m_hist[$];
  int         m_mode  = 2;   // 0 waiting for a press, 1 a button is held, 2 waiting for all-up
  int         m_idx   = 0;

  always @(posedge clk) begin
    logic [3:0] r, f, dly, nxt;
    int         rc;
    if (!rst) begin
      m_edge = 0;
      m_lvl  = '0;
      m_prev = '0;
      for (int i = 0; i < 4; i++) m_since[i] = -1;
      m_hist.delete();
      for (int i = 0; i < S; i++) m_hist.push_back(4'b0);
      m_mode = 2;
      m_idx  = 0;
    end else begin
      m_edge++;
      r  = m_lvl & ~m_prev;
      f  = ~m_lvl & m_prev;
      rc = $countones(r);
      if (m_mode == 0) begin
        if (rc > 0) begin
          if (enable && rc == 1) begin
            m_idx = $clog2(int'(r));
            exp_q.push_back(1);
            m_mode = 1;
          end else begin
            if (enable) exp_q.push_back(3);
            m_mode = 2;
          end
        end
      end else if (m_mode == 1) begin
        if ((int'(r) & ~(1 << m_idx)) != 0) begin
          exp_q.push_back(3);
          m_mode = 2;
        end else if (f[m_idx]) begin
          exp_q.push_back(2);
          m_mode = 0;
        end
      end else if (m_lvl == 4'b0) begin
        m_mode = 0;
      end
      // Debounce: the input seen S edges late must disagree across D consecutive ms ticks.
      dly = m_hist.pop_front();
      m_hist.push_back(btn_raw);
      nxt = m_lvl;
      for (int i = 0; i < 4; i++) begin
        if (dly[i] == m_lvl[i]) begin
          m_since[i] = -1;
        end else begin
          if (m_since[i] < 0) m_since[i] = m_edge;
          if ((m_edge % T == 0) && ((m_edge / T) - ((m_since[i] - 1) / T) >= D)) begin
            nxt[i]     = ~m_lvl[i];
            m_since[i] = -1;
          end
        end
      end
      m_prev = m_lvl;
      m_lvl  = nxt;
    end
  end

  // ---------------- monitor / scoreboard ----------------
  int mon_kind;
  int mon_exp;
  int mon_exp_idx = 0;

  always @(negedge clk) begin
    if (!rst) mon_exp_idx = 0;
    check("btn_level", int'(btn_level), int'(m_lvl));
    check("any_held", int'(any_held), int'(|m_lvl));
    check("pulse_exclusive", (int'(press_valid) + int'(release_valid) + int'(chord_err)) <= 1 ? 1 : 0, 1);
    mon_kind = press_valid ? 1 : release_valid ? 2 : chord_err ? 3 : 0;
    if (mon_kind != 0 || exp_q.size() != 0) begin
      mon_exp = (exp_q.size() != 0) ? exp_q.pop_front() : 0;
      check("event_kind", mon_kind, mon_exp);
      if (mon_exp == 1) mon_exp_idx = m_idx;
    end
    if (rst) check("press_idx", int'(press_idx), mon_exp_idx);
  end

  // ---------------- stimulus ----------------
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_press(input string name);
    int got;
    got = 0;
    for (int k = 0; k < 40 && got == 0; k++) begin
      @(negedge clk);
      if (press_valid) got = 1;
    end
    check(name, got, 1);
  endtask

  initial begin
    int lat;
    int hold;
    rst     = 1'b0;
    enable  = 1'b0;
    btn_raw = 4'b0;
    cyc(3);
    rst = 1'b1;

    // Idle after reset.
    cyc(20);

    // Single press of button 2 with latency bound.
    enable  = 1'b1;
    btn_raw = 4'b0100;
    lat = 0;
    for (int k = 1; k <= 40 && lat == 0; k++) begin
      @(negedge clk);
      if (btn_level[2]) lat = k;
    end
    check("latency_min", (lat >= S + (D - 1) * T + 1) ? 1 : 0, 1);
    check("latency_max", (lat != 0 && lat <= S + D * T) ? 1 : 0, 1);
    cyc(40 - lat);
    btn_raw = 4'b0;
    cyc(30);

    // Fast glitching on button 0 never gets through.
    for (int k = 0; k < 30; k++) begin
      btn_raw[0] = ~btn_raw[0];
      cyc(2);
    end
    btn_raw = 4'b0;
    cyc(20);

    // Chord: hold 1, add 3; then a clean press of 0.
    btn_raw = 4'b0010;
    wait_press("press_btn1_seen");
    btn_raw = 4'b1010;
    cyc(30);
    btn_raw = 4'b0;
    cyc(30);
    btn_raw = 4'b0001;
    cyc(30);
    btn_raw = 4'b0;
    cyc(30);

    // Button already stable when enable rises yields nothing; second press counts.
    enable  = 1'b0;
    btn_raw = 4'b0100;
    cyc(30);
    enable  = 1'b1;
    btn_raw = 4'b0;
    cyc(30);
    btn_raw = 4'b0100;
    cyc(30);
    btn_raw = 4'b0;
    cyc(30);

    // Reset while held; button keeps being held through re-debounce with events gated.
    btn_raw = 4'b0100;
    wait_press("press_btn2_seen");
    cyc(5);
    rst = 1'b0;
    cyc(1);
    rst    = 1'b1;
    enable = 1'b0;
    check("post_reset_level", int'(btn_level), 0);
    check("post_reset_pulses", int'({press_valid, release_valid, chord_err}), 0);
    cyc(30);
    btn_raw = 4'b0;
    cyc(30);
    enable  = 1'b1;
    btn_raw = 4'b0100;
    cyc(30);
    btn_raw = 4'b0;
    cyc(30);

    // Randomised traffic.
    for (int it = 0; it < 80; it++) begin
      case ($urandom_range(0, 5))
        0, 1, 2: btn_raw = 4'(1 << $urandom_range(0, 3));
        3:       btn_raw = 4'($urandom_range(0, 15));
        default: btn_raw = 4'b0;
      endcase
      enable = ($urandom_range(0, 9) < 8);
      hold   = int'($urandom_range(1, 30));
      if ($urandom_range(0, 19) == 0) begin
        rst = 1'b0;
        cyc(1);
        rst = 1'b1;
      end
      cyc(hold);
    end

    btn_raw = 4'b0;
    enable  = 1'b1;
    cyc(40);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
